ifetch_buffer: RTL

Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the ID/EX buffer and register-file read.
- Owns the PC and drives the synchronous instruction memory (1-cycle read latency).
- Holds a skid slot so no fetched word is lost while the hazard unit stalls.
- Presents pc/instruction/valid plus decoded rs1/rs2/rd fields to ID and the hazard/forwarding unit.
- Branch/jump redirects from EX kill in-flight fetches and insert bubbles.

---
 rtl/ifetch_buffer.sv | 109 ++++++++++
 1 files changed

// File: rtl/ifetch_buffer.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid slot.
// Owns the PC, drives a 1-cycle-latency instruction memory, handles stalls and EX redirects.
module ifetch_buffer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 14,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc4_o,
  output logic [31:0]        instr_o,
  output logic               valid_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [4:0]         rd_o,
  output logic               misalign_o
);

  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic        req_valid_q;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;

  logic        cand_valid;
  logic [31:0] cand_pc;
  logic [31:0] cand_instr;

  // Skid slot always holds the oldest fetched word, so it wins over the in-flight read.
  always_comb begin
    cand_valid = 1'b0;
    cand_pc    = 32'h0000_0000;
    cand_instr = NOP_INSTR;
    if (skid_valid) begin
      cand_valid = 1'b1;
      cand_pc    = skid_pc;
      cand_instr = skid_instr;
    end else if (req_valid_q) begin
      cand_valid = 1'b1;
      cand_pc    = req_pc_q;
      cand_instr = imem_rdata;
    end else begin
      cand_valid = 1'b0;
    end
  end

  assign imem_en   = !rst && !stall && !redirect;
  assign imem_addr = pc_q[IMEM_AW+1:2];

  assign pc4_o = pc_o + 32'd4;
  assign rs1_o = instr_o[19:15];
  assign rs2_o = instr_o[24:20];
  assign rd_o  = instr_o[11:7];

  // Fetch state and IF/ID register update; priority rst > redirect > stall > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= 32'h0000_0000;
      skid_valid  <= 1'b0;
      skid_pc     <= 32'h0000_0000;
      skid_instr  <= NOP_INSTR;
      valid_o     <= 1'b0;
      instr_o     <= NOP_INSTR;
      pc_o        <= 32'h0000_0000;
      misalign_o  <= 1'b0;
    end else if (redirect) begin
      pc_q        <= {redirect_pc[31:2], 2'b00};
      req_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      valid_o     <= 1'b0;
      instr_o     <= NOP_INSTR;
      misalign_o  <= |redirect_pc[1:0];
    end else if (stall) begin
      // The in-flight word would be lost next cycle, so park it unless the slot is taken.
      if (!skid_valid && req_valid_q) begin
        skid_valid <= 1'b1;
        skid_pc    <= req_pc_q;
        skid_instr <= imem_rdata;
      end
      req_valid_q <= 1'b0;
      misalign_o  <= 1'b0;
    end else begin
      if (cand_valid) begin
        valid_o <= 1'b1;
        pc_o    <= cand_pc;
        instr_o <= cand_instr;
      end else begin
        valid_o <= 1'b0;
        instr_o <= NOP_INSTR;
      end
      skid_valid  <= 1'b0;
      req_pc_q    <= pc_q;
      req_valid_q <= 1'b1;
      pc_q        <= pc_q + 32'd4;
      misalign_o  <= 1'b0;
    end
  end

endmodule
